// File: rtl/mem_block_copy.sv
// Byte-at-a-time block copy initiator for one memory bank (READ/WRITE per byte, then a Done pulse).
// Optional MEMCOPY_CHECKSUM_EN adds a Checksum output: modulo-2^DW sum of the bytes written.
module mem_block_copy #(
  parameter int AW = 8,
  parameter int DW = 8
) (
  input  logic          Clk,
  input  logic          Rst,
  input  logic          Start,
  input  logic [AW-1:0] SrcAddr,
  input  logic [AW-1:0] DstAddr,
  input  logic [AW-1:0] Length,
  output logic          Busy,
  output logic          Done,
  output logic [AW-1:0] Address,
  output logic [DW-1:0] WriteData,
  output logic          MemWrite,
  output logic          MemRead,
  input  logic [DW-1:0] ReadData
`ifdef MEMCOPY_CHECKSUM_EN
  ,
  output logic [DW-1:0] Checksum
`endif
);

  typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

  state_t        state, state_nxt;
  logic [AW-1:0] src, dst, len, cnt;
  logic [DW-1:0] buffer;
  logic          last_byte;

  assign last_byte = (cnt + AW'(1)) == len;

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) state <= IDLE;
    else      state <= state_nxt;
  end

  // Outputs decode registered state only, so reset clears them without a clock edge.
  always_comb begin
    state_nxt = state;
    Busy      = 1'b0;
    Done      = 1'b0;
    MemRead   = 1'b0;
    MemWrite  = 1'b0;
    Address   = '0;
    WriteData = '0;
    case (state)
      IDLE: begin
        if (Start) state_nxt = (Length == '0) ? DONE : READ;
      end
      READ: begin
        Busy      = 1'b1;
        MemRead   = 1'b1;
        Address   = src + cnt;
        state_nxt = WRITE;
      end
      WRITE: begin
        Busy      = 1'b1;
        MemWrite  = 1'b1;
        Address   = dst + cnt;
        WriteData = buffer;
        state_nxt = last_byte ? DONE : READ;
      end
      DONE: begin
        Done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      src      <= '0;
      dst      <= '0;
      len      <= '0;
      cnt      <= '0;
      buffer   <= '0;
`ifdef MEMCOPY_CHECKSUM_EN
      Checksum <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (Start) begin
            src      <= SrcAddr;
            dst      <= DstAddr;
            len      <= Length;
            cnt      <= '0;
`ifdef MEMCOPY_CHECKSUM_EN
            Checksum <= '0;
`endif
          end
        end
        READ: buffer <= ReadData;
        WRITE: begin
          cnt      <= cnt + AW'(1);
`ifdef MEMCOPY_CHECKSUM_EN
          Checksum <= Checksum + buffer;
`endif
        end
        default: ;
      endcase
    end
  end

endmodule
